// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a 4-digit multiplexed 7-segment display.
// Optional decimal-point capture is enabled by defining SEG7_DP_EN.
module seg7_scan_decoder #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  dig,
    input  logic [7:0]  seg,
    output logic [15:0] digits_bcd,
    output logic [13:0] value_bin,
    output logic        frame_valid,
    output logic        bcd_err,
    output logic        code_err,
    output logic        seq_err,
    output logic [3:0]  dp_out
);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_CONVERT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [3:0]       dig_r;
    logic [7:0]       seg_r;
    logic [CW-1:0]    settle_cnt;
    logic             armed;
    logic             changed;
    logic             dig_ok;
    logic [1:0]       dig_idx;
    logic             cap;
    logic [7:0]       match;
    logic             known;
    logic [3:0]       nib;
    logic             take;

    logic [1:0]       state;
    logic [1:0]       expected;
    logic [1:0]       conv_idx;
    logic [13:0]      acc;
    logic [13:0]      acc_next;
    logic [TW-1:0]    tmo_cnt;
    logic [3:0][3:0]  d_frame;
    logic             any_bad;

    assign changed = (dig != dig_r) || (seg != seg_r);
    assign cap     = armed && dig_ok && (settle_cnt == CW'(SETTLE_CYC - 1));

    always_comb begin
        dig_ok  = 1'b1;
        dig_idx = 2'd0;
        case (dig_r)
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: dig_ok  = 1'b0;
        endcase
    end

`ifdef SEG7_DP_EN
    assign match = {1'b1, seg_r[6:0]};
`else
    assign match = seg_r;
`endif

    always_comb begin
        known = 1'b1;
        nib   = 4'h0;
        case (match)
            8'hc0: nib = 4'h0;
            8'hf9: nib = 4'h1;
            8'ha4: nib = 4'h2;
            8'hb0: nib = 4'h3;
            8'h99: nib = 4'h4;
            8'h92: nib = 4'h5;
            8'h82: nib = 4'h6;
            8'hf8: nib = 4'h7;
            8'h80: nib = 4'h8;
            8'h90: nib = 4'h9;
            8'h88: nib = 4'hA;
            8'h83: nib = 4'hB;
            8'hc6: nib = 4'hC;
            8'ha1: nib = 4'hD;
            8'h86: nib = 4'hE;
            8'h8e: nib = 4'hF;
            8'hbf: nib = 4'hF;
            default: known = 1'b0;
        endcase
    end

    // A capture lands in the frame buffer whenever the FSM accepts it; a wrong
    // non-zero digit may also land, but the FSM drops to IDLE so it is overwritten.
    assign take = cap && (((state == S_IDLE) && (dig_idx == 2'd0)) || (state == S_CAPTURE));

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < 4; i++)
            if (d_frame[i] > 4'd9) any_bad = 1'b1;
    end

    assign acc_next = (acc << 3) + (acc << 1) + {10'd0, d_frame[conv_idx]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_r      <= 4'hF;
            seg_r      <= 8'hFF;
            settle_cnt <= '0;
            armed      <= 1'b1;
        end else begin
            dig_r <= dig;
            seg_r <= seg;
            if (changed) begin
                settle_cnt <= '0;
                armed      <= 1'b1;
            end else if (!dig_ok) begin
                settle_cnt <= '0;
            end else if (cap) begin
                armed <= 1'b0;
            end else if (settle_cnt != CW'(SETTLE_CYC - 1)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_frame <= '0;
        else if (take) d_frame[dig_idx] <= known ? nib : 4'h0;
    end

`ifdef SEG7_DP_EN
    logic [3:0] dp_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_frame <= '0;
            dp_out   <= '0;
        end else begin
            if (take) dp_frame[dig_idx] <= ~seg_r[7];
            if ((state == S_CONVERT) && (conv_idx == 2'd0)) dp_out <= dp_frame;
        end
    end
`else
    assign dp_out = 4'b0000;
`endif

    // Outputs load on the CONVERT->DONE edge so frame_valid is high while in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            expected    <= 2'd0;
            conv_idx    <= 2'd0;
            acc         <= '0;
            tmo_cnt     <= '0;
            digits_bcd  <= '0;
            value_bin   <= '0;
            frame_valid <= 1'b0;
            bcd_err     <= 1'b0;
            code_err    <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            seq_err     <= 1'b0;
            code_err    <= cap && !known;
            case (state)
                S_IDLE: begin
                    if (cap && (dig_idx == 2'd0)) begin
                        expected <= 2'd1;
                        tmo_cnt  <= '0;
                        state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (cap) begin
                        tmo_cnt <= '0;
                        if (dig_idx == expected) begin
                            if (expected == 2'd3) begin
                                acc      <= '0;
                                conv_idx <= 2'd3;
                                state    <= S_CONVERT;
                            end else begin
                                expected <= expected + 1'b1;
                            end
                        end else begin
                            seq_err <= 1'b1;
                            if (dig_idx == 2'd0) expected <= 2'd1;
                            else                 state    <= S_IDLE;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        seq_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_CONVERT: begin
                    acc      <= acc_next;
                    conv_idx <= conv_idx - 1'b1;
                    if (conv_idx == 2'd0) begin
                        frame_valid <= 1'b1;
                        digits_bcd  <= d_frame;
                        value_bin   <= any_bad ? 14'h3FFF : acc_next;
                        bcd_err     <= any_bad;
                        state       <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (default SETTLE_CYC=4).
module tb_seg7_scan_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  dig;
    logic [7:0]  seg;
    logic [15:0] digits_bcd;
    logic [13:0] value_bin;
    logic        frame_valid;
    logic        bcd_err;
    logic        code_err;
    logic        seq_err;
    logic [3:0]  dp_out;

    seg7_scan_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dig         (dig),
        .seg         (seg),
        .digits_bcd  (digits_bcd),
        .value_bin   (value_bin),
        .frame_valid (frame_valid),
        .bcd_err     (bcd_err),
        .code_err    (code_err),
        .seq_err     (seq_err),
        .dp_out      (dp_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int fv_cnt = 0, ce_cnt = 0, se_cnt = 0, fv_cyc = 0;
    logic [15:0] fv_dig = '0;
    logic [13:0] fv_val = '0;
    logic        fv_err = 1'b0;
    int n_cmp = 0, n_bad = 0;
    int t3 = 0, f0, c0, s0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt <= fv_cnt + 1;
            fv_cyc <= cyc;
            fv_dig <= digits_bcd;
            fv_val <= value_bin;
            fv_err <= bcd_err;
        end
        if (code_err) ce_cnt <= ce_cnt + 1;
        if (seq_err)  se_cnt <= se_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // idx<0 blanks the display; called at posedge+1, returns at posedge+1
    task automatic drive(input int idx, input logic [7:0] code, input int hold);
        if (idx < 0) dig = 4'hF;
        else         dig = ~(4'b0001 << idx);
        seg = code;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        drive(0, a, 20);
        drive(1, b, 20);
        drive(2, c, 20);
        t3 = cyc;
        drive(3, d, 20);
        drive(-1, 8'hFF, 6);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_digits"}, 32'(digits_bcd), 32'h0);
        chk({tag, "_value"}, 32'(value_bin), 32'h0);
        chk({tag, "_flags"}, {28'd0, frame_valid, bcd_err, code_err, seq_err}, 32'h0);
        chk({tag, "_dp"}, 32'(dp_out), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        dig   = 4'hF;
        seg   = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // basic frame 3210 and capture-to-valid latency (drive + 4 settle + 5)
        f0 = fv_cnt;
        frame(8'hc0, 8'hf9, 8'ha4, 8'hb0);
        chk("f3210_count", fv_cnt - f0, 1);
        chk("f3210_digits", 32'(fv_dig), 32'h3210);
        chk("f3210_value", 32'(fv_val), 32'd3210);
        chk("f3210_bcderr", 32'(fv_err), 0);
        chk("f3210_latency", fv_cyc - t3, 9);
        chk("f3210_hold", 32'(digits_bcd), 32'h3210);

        frame(8'h90, 8'h90, 8'h90, 8'h90);
        chk("f9999_digits", 32'(fv_dig), 32'h9999);
        chk("f9999_value", 32'(fv_val), 32'd9999);

        frame(8'h88, 8'hc6, 8'h80, 8'h80);
        chk("fhex_digits", 32'(fv_dig), 32'h88CA);
        chk("fhex_value", 32'(fv_val), 32'h3FFF);
        chk("fhex_bcderr", 32'(fv_err), 1);

        // out-of-order digit
        f0 = fv_cnt; s0 = se_cnt;
        drive(0, 8'hc0, 20);
        drive(2, 8'ha4, 20);
        drive(-1, 8'hFF, 6);
        chk("seq_pulse", se_cnt - s0, 1);
        chk("seq_no_frame", fv_cnt - f0, 0);
        frame(8'h92, 8'h99, 8'hb0, 8'ha4);
        chk("seq_recover_count", fv_cnt - f0, 1);
        chk("seq_recover_digits", 32'(fv_dig), 32'h2345);
        chk("seq_recover_value", 32'(fv_val), 32'd2345);

        // unknown code stores 0 and the frame continues
        c0 = ce_cnt;
        frame(8'h12, 8'hf9, 8'hf9, 8'hf9);
        chk("code_pulse", ce_cnt - c0, 1);
        chk("code_digits", 32'(fv_dig), 32'h1110);
        chk("code_value", 32'(fv_val), 32'd1110);

        // glitching seg never settles, so digits 1..3 find the FSM in IDLE
        f0 = fv_cnt; s0 = se_cnt; c0 = ce_cnt;
        for (int i = 0; i < 10; i++) drive(0, (i % 2) ? 8'hc0 : 8'hf9, 2);
        drive(-1, 8'hFF, 6);
        drive(1, 8'hf9, 20);
        drive(2, 8'hf9, 20);
        drive(3, 8'hf9, 20);
        drive(-1, 8'hFF, 6);
        chk("glitch_no_frame", fv_cnt - f0, 0);
        chk("glitch_no_seq", se_cnt - s0, 0);

        dig = 4'h0; seg = 8'hc0;
        repeat (20) @(posedge clk); #1;
        drive(1, 8'hf9, 20);
        drive(2, 8'hf9, 20);
        drive(3, 8'hf9, 20);
        drive(-1, 8'hFF, 6);
        chk("blank_no_frame", fv_cnt - f0, 0);
        chk("blank_no_code", ce_cnt - c0, 0);

        // reset in the middle of a frame
        drive(0, 8'hc0, 20);
        drive(1, 8'hf9, 20);
        rst_n = 1'b0;
        dig   = 4'hF;
        seg   = 8'hFF;
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        f0 = fv_cnt;
        frame(8'h80, 8'h80, 8'h80, 8'h90);
        chk("postrst_count", fv_cnt - f0, 1);
        chk("postrst_digits", 32'(fv_dig), 32'h9888);
        chk("postrst_value", 32'(fv_val), 32'd9888);

        // lit decimal point on digit1
        c0 = ce_cnt;
        frame(8'hc0, 8'h79, 8'ha4, 8'hb0);
`ifdef SEG7_DP_EN
        chk("dp_code", ce_cnt - c0, 0);
        chk("dp_digits", 32'(fv_dig), 32'h3210);
        chk("dp_out", 32'(dp_out), 32'b0010);
`else
        chk("dp_code", ce_cnt - c0, 1);
        chk("dp_digits", 32'(fv_dig), 32'h3200);
        chk("dp_out", 32'(dp_out), 32'b0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit multiplexed 7-segment driver.
- Samples the active-low scan lines `dig` and the active-low segment code `seg`, and recovers the displayed nibble of each digit.
- Once all four digits are captured in order, converts the frame from BCD to binary and pulses a valid strobe.
- Used as an on-chip loopback monitor for timing-measurement displays, and as a verification checker for display drivers.

Parameters:
- SETTLE_CYC, 4: consecutive cycles that `dig` and `seg` must be unchanged before a digit is captured.
- TIMEOUT_CYC, 1_000_000: maximum cycles allowed between captures inside a frame before the frame is abandoned.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dig  in  4  scan select, active-low one-hot: 1110=digit0, 1101=digit1, 1011=digit2, 0111=digit3
- seg  in  8  segment code, active-low; bit7 = decimal point
- digits_bcd  out  16  captured nibbles {d3,d2,d1,d0}
- value_bin  out  14  binary value d3*1000+d2*100+d1*10+d0
- frame_valid  out  1  one-cycle pulse; outputs updated in the same cycle
- bcd_err  out  1  qualified by frame_valid; some digit > 9
- code_err  out  1  one-cycle pulse; unknown segment code at capture
- seq_err  out  1  one-cycle pulse; out-of-order digit or timeout
- dp_out  out  4  per-digit decimal-point flags (see Optional Feature)

Behaviour:
- Reset values: all outputs 0. Internal state: IDLE, settle counter 0, armed=1. Reset mid-frame discards the partial frame.
- Input registration: `dig` and `seg` are registered once (sampled). Any change of either relative to the previous sample clears the settle counter and re-arms the capture.
- Valid `dig` value: exactly one bit low. Any other value (0000, 1111, multi-low) is blank: the settle counter is held at 0 and no capture occurs.
- Capture rule: when armed and the counter reaches SETTLE_CYC-1 with valid `dig`, capture once and disarm. At most one capture per `dig`/`seg` activation.
- Decode table (`seg`, 8-bit match):
  - c0=0, f9=1, a4=2, b0=3, 99=4, 92=5, 82=6, f8=7, 80=8, 90=9
  - 88=A, 83=b, c6=C, a1=d, 86=E, 8e=F
  - bf (dash) = F
- Unknown code at capture: pulse code_err in the next cycle. The digit stores 0 and the frame continues.
- FSM states: IDLE, CAPTURE, CONVERT, DONE.
  - IDLE: a capture of digit0 stores d0 and moves to CAPTURE with expected=1. Captures of other digits are ignored silently.
  - CAPTURE, expected digit captured: store it and increment expected. After digit3, go to CONVERT.
  - CAPTURE, wrong digit captured: pulse seq_err. If it was digit0, restart the frame (store d0, expected=1); otherwise go to IDLE.
  - CAPTURE, timeout: no capture for TIMEOUT_CYC cycles. Pulse seq_err and go to IDLE.
  - CONVERT: 4 cycles, processing d3 first. acc <= (acc<<3)+(acc<<1)+d. acc is 14 bits and cleared on entry.
  - DONE: one cycle. Assert frame_valid and load digits_bcd, value_bin and bcd_err. Return to IDLE.
- Conversion result:
  - If any digit > 9: value_bin = 14'h3FFF and bcd_err=1.
  - Otherwise value_bin = the exact value (max 9999, no overflow).
- Latency: digit3 captured at cycle T; frame_valid at T+5.
- Captures arriving during CONVERT or DONE are ignored.
- digits_bcd, value_bin and dp_out hold until the next DONE.

Optional Feature:
- Macro SEG7_DP_EN.
- Defined:
  - Codes are matched on seg[6:0] with bit 7 forced to 1.
  - dp_out[i] = ~seg[7] at capture of digit i; updated at DONE.
- Undefined:
  - Full 8-bit match, so a lit decimal point yields code_err.
  - dp_out is tied to 0.

Test Plan:
- Scan c0,f9,a4,b0 on digits 0..3, each held 20 cycles, SETTLE_CYC=4 -> frame_valid once; digits_bcd=16'h3210, value_bin=3210, bcd_err=0; frame_valid exactly 5 cycles after the digit3 capture.
- Scan 90 on all digits -> value_bin=9999. Then scan 88,c6,80,80 on digits 0..3 -> digits_bcd=16'h8_8_C_A, value_bin=14'h3FFF, bcd_err=1.
- Scan digit0, digit2 -> seq_err pulse, FSM in IDLE, no frame_valid. Then a full scan -> normal frame.
- Scan digit0 with seg=8'h12 -> code_err pulse. Complete the frame with f9,f9,f9 -> digits_bcd=16'h1110.
- Glitch: toggle `seg` every 2 cycles with SETTLE_CYC=4 -> no capture. Set dig=0000 -> no capture. Assert rst_n low mid-CAPTURE -> all outputs 0; next full frame decodes correctly.
- With SEG7_DP_EN: digit1 seg=8'h79 -> d1=1, dp_out=4'b0010. Without SEG7_DP_EN: same stimulus -> code_err pulse, dp_out=0.
